// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter sharing one SD-card sector port between the floppy (FDC) and ACSI clients.
// Grants one image-indexed request at a time, routes busy/done to the owner, and aborts unaccepted requests.
module sd_req_arbiter #(
    parameter logic [23:0] TIMEOUT = 24'd1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  fdc_rd_req,
    input  logic [1:0]  fdc_wr_req,
    input  logic [31:0] fdc_lba,
    output logic        fdc_busy,
    output logic        fdc_done,
    input  logic [1:0]  acsi_rd_req,
    input  logic [1:0]  acsi_wr_req,
    input  logic [31:0] acsi_lba,
    output logic        acsi_busy,
    output logic        acsi_done,
    output logic [3:0]  sd_rd,
    output logic [3:0]  sd_wr,
    output logic [31:0] sd_lba,
    input  logic        sd_busy,
    input  logic        sd_done,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, REQ, XFER, HOLD} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_FDC, OWN_ACSI} owner_t;

    state_t      state;
    owner_t      owner;
    logic        last_acsi;
    logic [23:0] timer;

    logic        fdc_any;
    logic        acsi_any;
    logic        grant_fdc;
    logic        grant_acsi;
    logic [3:0]  client_sel;

    // Result is {wr_onehot, rd_onehot}: lowest bit wins, read beats write on the same bit.
    function automatic logic [3:0] pick_req(input logic [1:0] rd, input logic [1:0] wr);
        if (rd[0])      return 4'b0001;
        else if (wr[0]) return 4'b0100;
        else if (rd[1]) return 4'b0010;
        else if (wr[1]) return 4'b1000;
        else            return 4'b0000;
    endfunction

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        fdc_any    = |{fdc_rd_req, fdc_wr_req};
        acsi_any   = |{acsi_rd_req, acsi_wr_req};
        grant_fdc  = fdc_any && (!acsi_any || last_acsi);
        grant_acsi = acsi_any && !grant_fdc;
        client_sel = 4'b0000;
        if (grant_fdc)
            client_sel = pick_req(fdc_rd_req, fdc_wr_req);
        else if (grant_acsi)
            client_sel = pick_req(acsi_rd_req, acsi_wr_req);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= OWN_NONE;
            last_acsi   <= 1'b1;
            timer       <= 24'd0;
            sd_rd       <= 4'b0000;
            sd_wr       <= 4'b0000;
            sd_lba      <= 32'd0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_fdc || grant_acsi) begin
                        owner     <= grant_fdc ? OWN_FDC : OWN_ACSI;
                        last_acsi <= grant_acsi;
                        timer     <= 24'd0;
                        state     <= REQ;
                        if (grant_fdc) begin
                            sd_lba <= fdc_lba;
                            sd_rd  <= {2'b00, client_sel[1:0]};
                            sd_wr  <= {2'b00, client_sel[3:2]};
                        end else begin
                            sd_lba <= acsi_lba;
                            sd_rd  <= {client_sel[1:0], 2'b00};
                            sd_wr  <= {client_sel[3:2], 2'b00};
                        end
                    end
                end
                REQ: begin
                    if (sd_busy) begin
                        sd_rd <= 4'b0000;
                        sd_wr <= 4'b0000;
                        state <= XFER;
                    end else if (TIMEOUT != 24'd0 && timer == TIMEOUT - 24'd1) begin
                        sd_rd       <= 4'b0000;
                        sd_wr       <= 4'b0000;
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else if (timer != 24'hFF_FFFF) begin
                        timer <= timer + 24'd1;
                    end
                end
                XFER: begin
                    if (sd_done)
                        state <= HOLD;
                end
                HOLD: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Owner is kept after an abort so the abort pulse still reaches the right client.
    always_comb begin
        fdc_busy  = sd_busy && owner == OWN_FDC  && (state == REQ || state == XFER);
        acsi_busy = sd_busy && owner == OWN_ACSI && (state == REQ || state == XFER);
        fdc_done  = (sd_done && owner == OWN_FDC  && state == XFER) || (timeout_err && owner == OWN_FDC);
        acsi_done = (sd_done && owner == OWN_ACSI && state == XFER) || (timeout_err && owner == OWN_ACSI);
    end

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Directed-vector bench for sd_req_arbiter with a short timeout.
module tb_sd_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  fdc_rd_req, fdc_wr_req;
    logic [31:0] fdc_lba;
    logic        fdc_busy, fdc_done;
    logic [1:0]  acsi_rd_req, acsi_wr_req;
    logic [31:0] acsi_lba;
    logic        acsi_busy, acsi_done;
    logic [3:0]  sd_rd, sd_wr;
    logic [31:0] sd_lba;
    logic        sd_busy, sd_done;
    logic        timeout_err;

    int n_vec = 0;
    int n_err = 0;

    sd_req_arbiter #(.TIMEOUT(24'd16)) dut (
        .clk(clk), .reset(reset),
        .fdc_rd_req(fdc_rd_req), .fdc_wr_req(fdc_wr_req), .fdc_lba(fdc_lba),
        .fdc_busy(fdc_busy), .fdc_done(fdc_done),
        .acsi_rd_req(acsi_rd_req), .acsi_wr_req(acsi_wr_req), .acsi_lba(acsi_lba),
        .acsi_busy(acsi_busy), .acsi_done(acsi_done),
        .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_lba(sd_lba),
        .sd_busy(sd_busy), .sd_done(sd_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        fdc_rd_req = 2'b00; fdc_wr_req = 2'b00; fdc_lba = 32'd0;
        acsi_rd_req = 2'b00; acsi_wr_req = 2'b00; acsi_lba = 32'd0;
        sd_busy = 1'b0; sd_done = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Accept, transfer and finish the current request; ends with the arbiter back in IDLE.
    task automatic serve(input string tag, input bit is_fdc, input bit drop);
        sd_busy = 1'b1;
        #1;
        check({tag, "_fdc_busy"},  {31'd0, fdc_busy},  {31'd0, is_fdc});
        check({tag, "_acsi_busy"}, {31'd0, acsi_busy}, {31'd0, !is_fdc});
        tick();
        check({tag, "_req_cleared"}, {24'd0, sd_rd, sd_wr}, 32'd0);
        if (drop) clear_inputs();
        sd_busy = 1'b1;
        sd_done = 1'b1;
        #1;
        check({tag, "_fdc_done"},  {31'd0, fdc_done},  {31'd0, is_fdc});
        check({tag, "_acsi_done"}, {31'd0, acsi_done}, {31'd0, !is_fdc});
        tick();
        sd_done = 1'b0;
        sd_busy = 1'b0;
        #1;
        check({tag, "_done_pulse"}, {30'd0, fdc_done, acsi_done}, 32'd0);
        tick();
    endtask

    initial begin
        clear_inputs();
        do_reset();
        check("reset_req",  {24'd0, sd_rd, sd_wr}, 32'd0);
        check("reset_lba",  sd_lba, 32'd0);
        check("reset_outs", {28'd0, timeout_err, fdc_done, acsi_done, fdc_busy}, 32'd0);

        // Single ACSI read.
        acsi_rd_req = 2'b01;
        acsi_lba    = 32'h1234_5678;
        tick();
        check("acsi_rd_grant", {28'd0, sd_rd}, 32'h4);
        check("acsi_rd_lba",   sd_lba, 32'h1234_5678);
        serve("acsi_rd", 1'b0, 1'b1);

        // Simultaneous requests after reset: FDC wins first.
        do_reset();
        fdc_wr_req  = 2'b10; fdc_lba  = 32'hAAAA_0001;
        acsi_rd_req = 2'b10; acsi_lba = 32'hBBBB_0002;
        tick();
        check("tie_fdc_wr",  {24'd0, sd_rd, sd_wr}, {24'd0, 4'b0000, 4'b0010});
        check("tie_fdc_lba", sd_lba, 32'hAAAA_0001);
        sd_busy = 1'b1;
        #1;
        check("tie_fdc_busy", {30'd0, fdc_busy, acsi_busy}, 32'h2);
        tick();
        fdc_wr_req = 2'b00;
        sd_done = 1'b1;
        #1;
        check("tie_fdc_done", {30'd0, fdc_done, acsi_done}, 32'h2);
        tick();
        sd_done = 1'b0;
        sd_busy = 1'b0;
        tick();
        tick();
        check("tie_acsi_rd",  {24'd0, sd_rd, sd_wr}, {24'd0, 4'b1000, 4'b0000});
        check("tie_acsi_lba", sd_lba, 32'hBBBB_0002);
        serve("tie_acsi", 1'b0, 1'b1);

        // Round robin with both clients requesting continuously; last grant was ACSI.
        fdc_rd_req  = 2'b01; fdc_lba  = 32'h0000_0F0F;
        acsi_wr_req = 2'b01; acsi_lba = 32'h0000_0A0A;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i % 2 == 0) begin
                check($sformatf("rr%0d_fdc", i), {24'd0, sd_rd, sd_wr}, {24'd0, 4'b0001, 4'b0000});
                check($sformatf("rr%0d_lba", i), sd_lba, 32'h0000_0F0F);
            end else begin
                check($sformatf("rr%0d_acsi", i), {24'd0, sd_rd, sd_wr}, {24'd0, 4'b0000, 4'b0100});
                check($sformatf("rr%0d_lba", i), sd_lba, 32'h0000_0A0A);
            end
            serve($sformatf("rr%0d", i), i % 2 == 0, 1'b0);
        end

        // Timeout: floppy read never accepted.
        do_reset();
        fdc_rd_req = 2'b01;
        tick();
        check("to_grant", {28'd0, sd_rd}, 32'h1);
        for (int i = 0; i < 15; i++) tick();
        check("to_still_req", {27'd0, sd_rd, timeout_err}, {27'd0, 4'b0001, 1'b0});
        fdc_rd_req = 2'b00;
        tick();
        check("to_req_dropped", {28'd0, sd_rd}, 32'h0);
        check("to_err_pulse",   {29'd0, timeout_err, fdc_done, acsi_done}, 32'h6);
        tick();
        check("to_pulse_end",   {29'd0, timeout_err, fdc_done, acsi_done}, 32'h0);

        // Reset mid-transfer drops the ACSI request and blocks late sd_done.
        do_reset();
        acsi_rd_req = 2'b01;
        tick();
        sd_busy = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        acsi_rd_req = 2'b00;
        sd_done = 1'b1;
        #1;
        check("rst_xfer_done", {29'd0, acsi_done, fdc_done, acsi_busy}, 32'h0);
        check("rst_xfer_req",  {24'd0, sd_rd, sd_wr}, 32'h0);
        sd_done = 1'b0;
        sd_busy = 1'b0;
        fdc_rd_req  = 2'b10;
        acsi_rd_req = 2'b01;
        tick();
        check("rst_xfer_fdc_first", {24'd0, sd_rd, sd_wr}, {24'd0, 4'b0010, 4'b0000});

        // Stray sd_done in IDLE, then read-over-write on the same bit.
        do_reset();
        sd_done = 1'b1;
        #1;
        check("stray_done", {30'd0, fdc_done, acsi_done}, 32'h0);
        tick();
        sd_done = 1'b0;
        fdc_rd_req = 2'b01;
        fdc_wr_req = 2'b01;
        tick();
        check("rd_over_wr", {24'd0, sd_rd, sd_wr}, {24'd0, 4'b0001, 4'b0000});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sd_req_arbiter.md
Name: sd_req_arbiter

Overview:
- Shares the single SD-card sector interface between the floppy controller (2 drive images) and the ACSI controller (2 hard-disk targets).
- Each client raises per-image read/write request levels plus a 32-bit LBA and holds them until it sees its busy indication.
- The arbiter grants one client at a time, round-robin, and drives a 4-bit image-indexed request to the SD card controller. It routes busy/done back to the granted client only and aborts requests the SD side never accepts.

Parameters:
- TIMEOUT, 24'd1_000_000, clk cycles to wait in REQ for sd_busy before aborting; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- fdc_rd_req  in  2  floppy read request level, bit = drive
- fdc_wr_req  in  2  floppy write request level, bit = drive
- fdc_lba  in  32  floppy sector address
- fdc_busy  out  1  SD accepted floppy request
- fdc_done  out  1  floppy sector complete
- acsi_rd_req  in  2  ACSI read request level, bit = target
- acsi_wr_req  in  2  ACSI write request level, bit = target
- acsi_lba  in  32  ACSI sector address
- acsi_busy  out  1  SD accepted ACSI request
- acsi_done  out  1  ACSI sector complete
- sd_rd  out  4  read request to SD controller; [1:0] floppy drives, [3:2] ACSI targets
- sd_wr  out  4  write request, same indexing
- sd_lba  out  32  latched LBA of granted request
- sd_busy  in  1  SD controller accepted request / transfer in progress
- sd_done  in  1  SD controller sector finished (1-cycle pulse)
- timeout_err  out  1  1-cycle pulse when a request is aborted

Behaviour:
- Reset values: state=IDLE, sd_rd=sd_wr=0, sd_lba=0, timeout_err=0, owner=none, last_grant=ACSI (so FDC wins the first tie). Reset mid-transfer drops the request immediately; any later sd_busy/sd_done is not forwarded.
- IDLE:
  - fdc_any = |{fdc_rd_req, fdc_wr_req}; acsi_any likewise.
  - Only FDC or only ACSI requesting: that client is granted.
  - Both requesting: the client that is not last_grant is granted, and last_grant is updated.
  - Within the granted client: lowest set bit wins; read wins over write on the same bit.
  - On grant (registered, 1 cycle after request seen): sd_lba <= client lba; exactly one bit of sd_rd/sd_wr set; owner recorded; state -> REQ; timer cleared.
- REQ:
  - Request bit held.
  - When sd_busy=1: clear sd_rd/sd_wr, state -> XFER.
  - When timer reaches TIMEOUT-1 (TIMEOUT≠0) without sd_busy: clear request, pulse timeout_err and owner's done for 1 cycle, state -> IDLE.
  - sd_busy takes precedence over timeout in the same cycle.
- XFER:
  - On sd_done: state -> HOLD.
  - If the client lowers its request after busy, nothing changes.
- HOLD:
  - Exactly 1 cycle; lets the client's request level clear before re-arbitration.
  - state -> IDLE.
- Forwarding (combinational, zero latency):
  - fdc_busy = sd_busy & owner==FDC & state∈{REQ,XFER}; acsi_busy analog.
  - fdc_done = (sd_done & owner==FDC & state==XFER) | abort pulse; acsi analog.
  - sd_done seen outside XFER is ignored.
- Multi-sector: a client re-raising its request after done (e.g. ACSI next-sector) rejoins arbitration normally; no lock. The other client may be served between sectors.
- Requests change only in IDLE sampling; LBA is latched at grant and stable for the whole transaction.
- Timer: 24-bit, saturates; counts only in REQ.

Test Plan:
- Single ACSI read: acsi_rd_req=2'b01, acsi_lba=0x12345678 → next cycle sd_rd=4'b0100, sd_lba=0x12345678. sd_busy → sd_rd=0, acsi_busy=1. sd_done → acsi_done=1 for 1 cycle, fdc_done=0.
- Simultaneous after reset: fdc_wr_req=2'b10 and acsi_rd_req=2'b10 together → sd_wr=4'b0010 first. After completion and HOLD, ACSI granted with sd_rd=4'b1000, sd_lba=acsi_lba.
- Round-robin fairness: both clients re-request continuously for 4 transactions → grants alternate FDC, ACSI, FDC, ACSI.
- Timeout with TIMEOUT=16: floppy read, sd_busy never asserted → after 16 cycles in REQ, sd_rd=0, timeout_err and fdc_done pulse 1 cycle, state IDLE.
- Reset mid-XFER: reset during ACSI transfer, then sd_done → acsi_done stays 0, all sd_rd/sd_wr=0, next FDC request granted first.
- Stray sd_done in IDLE → no done output on either client.
